// File: rtl/reg_access_ctrl.sv
// ----------------------------------------------------------------------------
// reg_access_ctrl : register-file read / ALU / write-back sequencer, 8-bit CPU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_access_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   INSTRUCTION,
  input  logic          INSTR_VALID,
  output logic          INSTR_READY,
  output logic [AW-1:0] OUT1ADDRESS,
  output logic [AW-1:0] OUT2ADDRESS,
  input  logic [DW-1:0] OUT1,
  input  logic [DW-1:0] OUT2,
  output logic [AW-1:0] INADDRESS,
  output logic [DW-1:0] IN,
  output logic          WRITE,
  output logic [2:0]    ALUOP,
  output logic [DW-1:0] OPERAND1,
  output logic [DW-1:0] OPERAND2,
  output logic          OP_VALID,
  input  logic [DW-1:0] ALURESULT,
  input  logic          RES_VALID,
  output logic          ILLEGAL,
  output logic          TIMED_OUT
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

  logic [1:0]    state;
  logic [2:0]    cur_op;
  logic [AW-1:0] dest;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    alu_sel;
  logic [7:0]    opcode;

  // Only a subset of instruction bits is decoded; fold the rest away.
  logic unused_instr;
  assign unused_instr = ^INSTRUCTION;

  assign opcode      = INSTRUCTION[31:24];
  assign INSTR_READY = (state == IDLE) && !RESET;

  always_comb begin
    alu_sel = 3'b000;
    case (cur_op)
      OP_ADD, OP_SUB: alu_sel = 3'b001;
      OP_AND:         alu_sel = 3'b010;
      OP_OR:          alu_sel = 3'b011;
      default:        alu_sel = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cur_op      <= '0;
      dest        <= '0;
      wait_cnt    <= '0;
      OUT1ADDRESS <= '0;
      OUT2ADDRESS <= '0;
      INADDRESS   <= '0;
      IN          <= '0;
      WRITE       <= 1'b0;
      ALUOP       <= '0;
      OPERAND1    <= '0;
      OPERAND2    <= '0;
      OP_VALID    <= 1'b0;
      ILLEGAL     <= 1'b0;
      TIMED_OUT   <= 1'b0;
    end else begin
      WRITE     <= 1'b0;
      ILLEGAL   <= 1'b0;
      TIMED_OUT <= 1'b0;
      case (state)
        IDLE: begin
          if (INSTR_VALID) begin
            if (opcode == 8'h00) begin
              // loadi needs no operands: write back straight from the immediate
              INADDRESS <= INSTRUCTION[16 +: AW];
              IN        <= INSTRUCTION[DW-1:0];
              WRITE     <= 1'b1;
              state     <= WB;
            end else if (opcode <= 8'h05) begin
              cur_op      <= INSTRUCTION[26:24];
              dest        <= INSTRUCTION[16 +: AW];
              OUT1ADDRESS <= INSTRUCTION[8 +: AW];
              OUT2ADDRESS <= INSTRUCTION[0 +: AW];
              state       <= READ;
            end else begin
              ILLEGAL <= 1'b1;
            end
          end
        end
        READ: begin
          OPERAND1 <= (cur_op == OP_MOV) ? '0 : OUT1;
          OPERAND2 <= (cur_op == OP_SUB) ? (~OUT2 + DW'(1)) : OUT2;
          ALUOP    <= alu_sel;
          OP_VALID <= 1'b1;
          wait_cnt <= '0;
          state    <= EXEC;
        end
        EXEC: begin
          if (RES_VALID) begin
            OP_VALID  <= 1'b0;
            INADDRESS <= dest;
            IN        <= ALURESULT;
            WRITE     <= 1'b1;
            state     <= WB;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            OP_VALID  <= 1'b0;
            TIMED_OUT <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reg_access_ctrl : directed self-checking bench for reg_access_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  OUT1ADDRESS, OUT2ADDRESS, INADDRESS;
  logic [7:0]  OUT1, OUT2, IN, OPERAND1, OPERAND2, ALURESULT;
  logic        WRITE, OP_VALID, RES_VALID, ILLEGAL, TIMED_OUT;
  logic [2:0]  ALUOP;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  reg_access_ctrl #(.DW(8), .AW(3), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .INADDRESS(INADDRESS), .IN(IN), .WRITE(WRITE),
    .ALUOP(ALUOP), .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .OP_VALID(OP_VALID),
    .ALURESULT(ALURESULT), .RES_VALID(RES_VALID), .ILLEGAL(ILLEGAL), .TIMED_OUT(TIMED_OUT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  saw_write;

    RESET = 1'b1; INSTRUCTION = '0; INSTR_VALID = 1'b0;
    OUT1 = '0; OUT2 = '0; ALURESULT = '0; RES_VALID = 1'b0;
    tick(); tick();
    chk("rst_write", {31'd0, WRITE}, 32'd0);
    chk("rst_opvalid", {31'd0, OP_VALID}, 32'd0);
    chk("rst_in", {24'd0, IN}, 32'd0);
    chk("rst_inaddr", {29'd0, INADDRESS}, 32'd0);
    chk("rst_ready", {31'd0, INSTR_READY}, 32'd0);
    RESET = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, INSTR_READY}, 32'd1);

    // loadi r2, 0x1F
    INSTRUCTION = 32'h0002001F; INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0; INSTRUCTION = 32'hDEADBEEF;
    chk("ldi_write", {31'd0, WRITE}, 32'd1);
    chk("ldi_inaddr", {29'd0, INADDRESS}, 32'd2);
    chk("ldi_in", {24'd0, IN}, 32'h1F);
    chk("ldi_ready_low", {31'd0, INSTR_READY}, 32'd0);
    tick();
    chk("ldi_write_end", {31'd0, WRITE}, 32'd0);
    chk("ldi_ready_back", {31'd0, INSTR_READY}, 32'd1);
    chk("ldi_in_hold", {24'd0, IN}, 32'h1F);

    // add r4 = r1 + r2, result ready in first EXEC cycle
    INSTRUCTION = 32'h02040102; INSTR_VALID = 1'b1; OUT1 = 8'h05; OUT2 = 8'h03;
    tick();
    INSTR_VALID = 1'b0;
    chk("add_addr1", {29'd0, OUT1ADDRESS}, 32'd1);
    chk("add_addr2", {29'd0, OUT2ADDRESS}, 32'd2);
    chk("add_read_opv", {31'd0, OP_VALID}, 32'd0);
    RES_VALID = 1'b1; ALURESULT = 8'h08;
    tick();
    chk("add_opv", {31'd0, OP_VALID}, 32'd1);
    chk("add_opnd1", {24'd0, OPERAND1}, 32'h05);
    chk("add_opnd2", {24'd0, OPERAND2}, 32'h03);
    chk("add_aluop", {29'd0, ALUOP}, 32'd1);
    chk("add_nowrite_yet", {31'd0, WRITE}, 32'd0);
    tick();
    RES_VALID = 1'b0;
    chk("add_write", {31'd0, WRITE}, 32'd1);
    chk("add_inaddr", {29'd0, INADDRESS}, 32'd4);
    chk("add_in", {24'd0, IN}, 32'h08);
    chk("add_opv_clr", {31'd0, OP_VALID}, 32'd0);
    tick();
    chk("add_write_end", {31'd0, WRITE}, 32'd0);
    chk("add_ready", {31'd0, INSTR_READY}, 32'd1);

    // sub r3 = r1 - r2, result after 4 EXEC cycles
    INSTRUCTION = 32'h03030102; INSTR_VALID = 1'b1; OUT1 = 8'h09; OUT2 = 8'h01;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    chk("sub_opnd2", {24'd0, OPERAND2}, 32'hFF);
    chk("sub_aluop", {29'd0, ALUOP}, 32'd1);
    OUT1 = 8'h77; OUT2 = 8'h66;
    tick(); tick(); tick();
    chk("sub_opv_held", {31'd0, OP_VALID}, 32'd1);
    chk("sub_opnd1_stable", {24'd0, OPERAND1}, 32'h09);
    chk("sub_opnd2_stable", {24'd0, OPERAND2}, 32'hFF);
    chk("sub_no_write", {31'd0, WRITE}, 32'd0);
    RES_VALID = 1'b1; ALURESULT = 8'h08;
    tick();
    RES_VALID = 1'b0;
    chk("sub_write", {31'd0, WRITE}, 32'd1);
    chk("sub_inaddr", {29'd0, INADDRESS}, 32'd3);
    chk("sub_in", {24'd0, IN}, 32'h08);
    tick();

    // mov r5 = r7 : operand1 forced to zero, forward op
    INSTRUCTION = 32'h01050307; INSTR_VALID = 1'b1; OUT1 = 8'hAA; OUT2 = 8'h5A;
    tick();
    INSTR_VALID = 1'b0;
    chk("mov_addr2", {29'd0, OUT2ADDRESS}, 32'd7);
    tick();
    chk("mov_opnd1", {24'd0, OPERAND1}, 32'h00);
    chk("mov_opnd2", {24'd0, OPERAND2}, 32'h5A);
    chk("mov_aluop", {29'd0, ALUOP}, 32'd0);
    RES_VALID = 1'b1; ALURESULT = 8'h5A;
    tick();
    RES_VALID = 1'b0;
    chk("mov_in", {24'd0, IN}, 32'h5A);
    chk("mov_inaddr", {29'd0, INADDRESS}, 32'd5);
    tick();

    // illegal opcode
    INSTRUCTION = 32'h07000000; INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    chk("ill_pulse", {31'd0, ILLEGAL}, 32'd1);
    chk("ill_no_write", {31'd0, WRITE}, 32'd0);
    chk("ill_ready", {31'd0, INSTR_READY}, 32'd1);
    tick();
    chk("ill_pulse_end", {31'd0, ILLEGAL}, 32'd0);

    // and r6 with RES_VALID withheld: timeout after 15 EXEC cycles
    INSTRUCTION = 32'h04060102; INSTR_VALID = 1'b1; OUT1 = 8'h0F; OUT2 = 8'h3C;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    chk("and_aluop", {29'd0, ALUOP}, 32'd2);
    n = 0; saw_write = 1'b0;
    while (OP_VALID && n < 20) begin
      n++;
      if (WRITE) saw_write = 1'b1;
      tick();
    end
    chk("to_opv_cycles", n, 32'd15);
    chk("to_pulse", {31'd0, TIMED_OUT}, 32'd1);
    chk("to_no_write", {31'd0, saw_write | WRITE}, 32'd0);
    chk("to_ready", {31'd0, INSTR_READY}, 32'd1);
    tick();
    chk("to_pulse_end", {31'd0, TIMED_OUT}, 32'd0);

    // or r1, reset asserted while in EXEC
    INSTRUCTION = 32'h05010203; INSTR_VALID = 1'b1; OUT1 = 8'h11; OUT2 = 8'h22;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    chk("or_aluop", {29'd0, ALUOP}, 32'd3);
    chk("or_opv", {31'd0, OP_VALID}, 32'd1);
    RESET = 1'b1; RES_VALID = 1'b1; ALURESULT = 8'h33;
    tick();
    chk("mrst_opv", {31'd0, OP_VALID}, 32'd0);
    chk("mrst_write", {31'd0, WRITE}, 32'd0);
    chk("mrst_aluop", {29'd0, ALUOP}, 32'd0);
    chk("mrst_opnd1", {24'd0, OPERAND1}, 32'd0);
    RESET = 1'b0;
    tick();
    chk("mrst_write_after", {31'd0, WRITE}, 32'd0);
    chk("mrst_ready", {31'd0, INSTR_READY}, 32'd1);
    RES_VALID = 1'b0;

    // loadi r7, 0x55 after the reset
    INSTRUCTION = 32'h00070055; INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    chk("ldi2_write", {31'd0, WRITE}, 32'd1);
    chk("ldi2_inaddr", {29'd0, INADDRESS}, 32'd7);
    chk("ldi2_in", {24'd0, IN}, 32'h55);
    tick();
    chk("ldi2_write_end", {31'd0, WRITE}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
